// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU arbiter: per-port FSM states and default widths.
package lsu_pkg;
  localparam int LMEM_DEF = 8;
  localparam int TAM_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;
endpackage

// File: rtl/lsu_port_fsm.sv
// One core port: latches an accepted request, strobes DataMEM once, captures
// the read data and presents a single-cycle response.
module lsu_port_fsm
  import lsu_pkg::*;
#(
  parameter int Lmem = LMEM_DEF,
  parameter int TAM  = TAM_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_accept,
  input  logic           i_write,
  input  logic [TAM-1:0] i_addr,
  input  logic [TAM-1:0] i_data,
  input  logic [TAM-1:0] i_mem_rdata,
  output logic           o_ready_base,
  output logic           o_resp_valid,
  output logic [TAM-1:0] o_resp_data,
  output logic           o_resp_err,
  output logic [TAM-1:0] o_data_in,
  output logic [TAM-1:0] o_data_addr,
  output logic           o_data_write,
  output logic           o_data_load
);
  lsu_state_t     r_state;
  lsu_state_t     w_state_next;
  logic [TAM-1:0] r_addr;
  logic [TAM-1:0] r_data;
  logic           r_write;
  logic           r_err;
  logic [TAM-1:0] r_resp_data;
  logic           w_take;

  assign w_take = i_accept & o_ready_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take) begin
        r_addr  <= i_addr;
        r_data  <= i_data;
        r_write <= i_write;
        r_err   <= (i_addr[TAM-1:Lmem] != '0);
      end
      // Memory data is valid exactly while WAIT; stores and faulted requests report 0.
      if (r_state == WAIT)
        r_resp_data <= (!r_write && !r_err) ? i_mem_rdata : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_data_write = 1'b0;
    o_data_load  = 1'b0;
    o_ready_base = (r_state == IDLE) || (r_state == RESP);
    case (r_state)
      IDLE:  if (w_take) w_state_next = ISSUE;
      ISSUE: begin
        o_data_write = r_write & ~r_err;
        o_data_load  = ~r_write & ~r_err;
        w_state_next = WAIT;
      end
      WAIT:  w_state_next = RESP;
      RESP:  w_state_next = w_take ? ISSUE : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign o_resp_valid = (r_state == RESP);
  assign o_resp_err   = (r_state == RESP) & r_err;
  assign o_resp_data  = r_resp_data;
  assign o_data_in    = r_data;
  assign o_data_addr  = r_addr;
endmodule

// File: rtl/lsu_arbiter.sv
// Two-core load/store arbiter in front of DataMEM: per-port FSMs plus
// round-robin resolution of same-address conflicts involving a store.
module lsu_arbiter
  import lsu_pkg::*;
#(
  parameter int Ncores = 2,
  parameter int Lmem   = LMEM_DEF,
  parameter int TAM    = TAM_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid0,
  input  logic              reqValid1,
  input  logic              reqWrite0,
  input  logic              reqWrite1,
  input  logic [TAM-1:0]    reqAddr0,
  input  logic [TAM-1:0]    reqAddr1,
  input  logic [TAM-1:0]    reqData0,
  input  logic [TAM-1:0]    reqData1,
  output logic              reqReady0,
  output logic              reqReady1,
  output logic              respValid0,
  output logic              respValid1,
  output logic [TAM-1:0]    respData0,
  output logic [TAM-1:0]    respData1,
  output logic              respErr0,
  output logic              respErr1,
  output logic [TAM-1:0]    dataIN0,
  output logic [TAM-1:0]    dataIN1,
  output logic [TAM-1:0]    dataADDR0,
  output logic [TAM-1:0]    dataADDR1,
  output logic [Ncores-1:0] dataWrite,
  output logic [Ncores-1:0] dataLoad,
  input  logic [TAM-1:0]    dataOUT0,
  input  logic [TAM-1:0]    dataOUT1,
  output logic [7:0]        conflictCnt
);
  logic           r_rr_ptr;
  logic [7:0]     r_conflict_cnt;
  logic           w_conflict;
  logic [1:0]     w_ready_base;
  logic [1:0]     w_want;
  logic [1:0]     w_ready;
  logic [1:0]     w_valid;
  logic [1:0]     w_write;
  logic [1:0]     w_resp_valid;
  logic [1:0]     w_resp_err;
  logic [TAM-1:0] w_addr      [2];
  logic [TAM-1:0] w_data      [2];
  logic [TAM-1:0] w_mem_rdata [2];
  logic [TAM-1:0] w_resp_data [2];
  logic [TAM-1:0] w_data_in   [2];
  logic [TAM-1:0] w_data_addr [2];

  assign w_valid        = {reqValid1, reqValid0};
  assign w_write        = {reqWrite1, reqWrite0};
  assign w_addr[0]      = reqAddr0;
  assign w_addr[1]      = reqAddr1;
  assign w_data[0]      = reqData0;
  assign w_data[1]      = reqData1;
  assign w_mem_rdata[0] = dataOUT0;
  assign w_mem_rdata[1] = dataOUT1;

  assign w_want     = w_valid & w_ready_base;
  // Loads to the same word never clash; only a store makes ordering matter.
  assign w_conflict = w_want[0] & w_want[1] & (|w_write) &
                      (reqAddr0[Lmem-1:0] == reqAddr1[Lmem-1:0]);
  assign w_ready[0] = w_ready_base[0] & ~(w_conflict & r_rr_ptr);
  assign w_ready[1] = w_ready_base[1] & ~(w_conflict & ~r_rr_ptr);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      lsu_port_fsm #(.Lmem(Lmem), .TAM(TAM)) u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_accept     (w_valid[gi] & w_ready[gi]),
        .i_write      (w_write[gi]),
        .i_addr       (w_addr[gi]),
        .i_data       (w_data[gi]),
        .i_mem_rdata  (w_mem_rdata[gi]),
        .o_ready_base (w_ready_base[gi]),
        .o_resp_valid (w_resp_valid[gi]),
        .o_resp_data  (w_resp_data[gi]),
        .o_resp_err   (w_resp_err[gi]),
        .o_data_in    (w_data_in[gi]),
        .o_data_addr  (w_data_addr[gi]),
        .o_data_write (dataWrite[gi]),
        .o_data_load  (dataLoad[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr       <= 1'b0;
      r_conflict_cnt <= '0;
    end else if (w_conflict) begin
      r_rr_ptr <= ~r_rr_ptr;
      if (r_conflict_cnt != 8'hFF)
        r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign reqReady0   = w_ready[0];
  assign reqReady1   = w_ready[1];
  assign respValid0  = w_resp_valid[0];
  assign respValid1  = w_resp_valid[1];
  assign respErr0    = w_resp_err[0];
  assign respErr1    = w_resp_err[1];
  assign respData0   = w_resp_data[0];
  assign respData1   = w_resp_data[1];
  assign dataIN0     = w_data_in[0];
  assign dataIN1     = w_data_in[1];
  assign dataADDR0   = w_data_addr[0];
  assign dataADDR1   = w_data_addr[1];
  assign conflictCnt = r_conflict_cnt;
endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter with a behavioural 256-word DataMEM.
module tb_lsu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [15:0] req_addr [2];
  logic [15:0] req_data [2];
  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_err;
  logic [15:0] resp_data [2];
  logic [15:0] data_in   [2];
  logic [15:0] data_addr [2];
  logic [1:0]  data_write;
  logic [1:0]  data_load;
  logic [15:0] dout      [2];
  logic [7:0]  conflict_cnt;
  logic [15:0] mem [256];

  int n_checks = 0;
  int n_errors = 0;
  bit exp_rr;

  always #5 clk = ~clk;

  lsu_arbiter dut (
    .clk(clk), .rst(rst),
    .reqValid0(req_valid[0]), .reqValid1(req_valid[1]),
    .reqWrite0(req_write[0]), .reqWrite1(req_write[1]),
    .reqAddr0(req_addr[0]), .reqAddr1(req_addr[1]),
    .reqData0(req_data[0]), .reqData1(req_data[1]),
    .reqReady0(req_ready[0]), .reqReady1(req_ready[1]),
    .respValid0(resp_valid[0]), .respValid1(resp_valid[1]),
    .respData0(resp_data[0]), .respData1(resp_data[1]),
    .respErr0(resp_err[0]), .respErr1(resp_err[1]),
    .dataIN0(data_in[0]), .dataIN1(data_in[1]),
    .dataADDR0(data_addr[0]), .dataADDR1(data_addr[1]),
    .dataWrite(data_write), .dataLoad(data_load),
    .dataOUT0(dout[0]), .dataOUT1(dout[1]),
    .conflictCnt(conflict_cnt)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    mem[5]  <= 16'h5A5A;
    dout[0] <= 16'h0000;
    dout[1] <= 16'h0000;
  end

  always @(posedge clk) begin
    if (data_write[0]) mem[data_addr[0][7:0]] <= data_in[0];
    if (data_write[1]) mem[data_addr[1][7:0]] <= data_in[1];
    if (data_load[0])  dout[0] <= mem[data_addr[0][7:0]];
    if (data_load[1])  dout[1] <= mem[data_addr[1][7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Full request on one port from IDLE: accept, strobe, wait, response.
  task automatic single_req(input int p, input bit wr, input logic [15:0] addr,
                            input logic [15:0] data, input logic [15:0] exp_rdata,
                            input bit exp_err, input bit exp_strobe);
    @(negedge clk);
    req_valid[p] = 1'b1; req_write[p] = wr; req_addr[p] = addr; req_data[p] = data;
    #1 check("ready", {31'd0, req_ready[p]}, 32'd1);
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    check("strobe_wr", {31'd0, data_write[p]}, {31'd0, exp_strobe & wr});
    check("strobe_ld", {31'd0, data_load[p]}, {31'd0, exp_strobe & ~wr});
    @(posedge clk); #1;
    check("wait_rv", {31'd0, resp_valid[p]}, 32'd0);
    check("wait_strobe", {30'd0, data_write | data_load}, 32'd0);
    @(posedge clk); #1;
    check("resp_rv", {31'd0, resp_valid[p]}, 32'd1);
    check("resp_data", {16'd0, resp_data[p]}, {16'd0, exp_rdata});
    check("resp_err", {31'd0, resp_err[p]}, {31'd0, exp_err});
    $display("txn port=%0d wr=%0d addr=%h data=%h -> rdata=%h err=%0d",
             p, wr, addr, data, resp_data[p], resp_err[p]);
    @(posedge clk); #1;
    check("resp_pulse", {31'd0, resp_valid[p]}, 32'd0);
  endtask

  initial begin
    req_addr[0] = '0; req_addr[1] = '0; req_data[0] = '0; req_data[1] = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_strobes", {28'd0, data_write, data_load}, 32'd0);
    check("rst_resp", {28'd0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", {resp_data[1], resp_data[0]}, 32'd0);
    check("rst_din", {data_in[1], data_in[0]}, 32'd0);
    check("rst_daddr", {data_addr[1], data_addr[0]}, 32'd0);
    check("rst_cnt", {24'd0, conflict_cnt}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Store then load back on port 0.
    single_req(0, 1'b1, 16'h0012, 16'h1234, 16'h0000, 1'b0, 1'b1);
    single_req(0, 1'b0, 16'h0012, 16'h0000, 16'h1234, 1'b0, 1'b1);

    // Same-address store conflict: port 0 wins, port 1 follows next cycle.
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b11;
    req_addr[0] = 16'h0040; req_addr[1] = 16'h0040;
    req_data[0] = 16'hAAAA; req_data[1] = 16'hBBBB;
    #1 check("cf_ready", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("cf_cnt", {24'd0, conflict_cnt}, 32'd1);
    check("cf_wr0", {30'd0, data_write}, 32'd1);
    check("cf_ready1", {31'd0, req_ready[1]}, 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("cf_wr1", {30'd0, data_write}, 32'd2);
    $display("txn conflict store addr=0040 cnt=%0d", conflict_cnt);
    repeat (4) @(posedge clk);
    single_req(0, 1'b0, 16'h0040, 16'h0000, 16'hBBBB, 1'b0, 1'b1);

    // Two loads to the same word are both accepted.
    @(negedge clk);
    req_valid = 2'b11; req_write = 2'b00;
    req_addr[0] = 16'h0005; req_addr[1] = 16'h0005;
    #1 check("ll_ready", {30'd0, req_ready}, 32'd3);
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("ll_load", {30'd0, data_load}, 32'd3);
    check("ll_cnt", {24'd0, conflict_cnt}, 32'd1);
    repeat (2) @(posedge clk); #1;
    check("ll_rv", {30'd0, resp_valid}, 32'd3);
    check("ll_data", {resp_data[1], resp_data[0]}, 32'h5A5A5A5A);
    $display("txn dual load addr=0005 rdata=%h/%h", resp_data[0], resp_data[1]);
    @(posedge clk);

    // Out-of-range load: no strobe, error response with zero data.
    single_req(0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1'b0);

    // Reset during port 1 ISSUE drops the strobe without a clock edge.
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 16'h0030; req_data[1] = 16'h7777;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("ar_issue", {30'd0, data_write}, 32'd2);
    #2 rst = 1'b0;
    #1;
    check("ar_drop", {30'd0, data_write}, 32'd0);
    check("ar_cnt", {24'd0, conflict_cnt}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("ar_norv", {31'd0, resp_valid[1]}, 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("ar_norv_post", {31'd0, resp_valid[1]}, 32'd0);
    end
    $display("txn reset abort port=1");
    single_req(1, 1'b1, 16'h0031, 16'h9999, 16'h0000, 1'b0, 1'b1);
    single_req(1, 1'b0, 16'h0031, 16'h0000, 16'h9999, 1'b0, 1'b1);

    // 300 forced conflicts; winner alternates starting from port 0 after reset.
    exp_rr = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req_valid = 2'b11; req_write = 2'b11;
      req_addr[0] = 16'h0020; req_addr[1] = 16'h0020;
      req_data[0] = 16'(i); req_data[1] = 16'(i + 1000);
      #1 check("sat_ready", {30'd0, req_ready}, exp_rr ? 32'd2 : 32'd1);
      @(posedge clk); #1;
      req_valid[exp_rr] = 1'b0;
      check("sat_loser_ready", {31'd0, req_ready[~exp_rr]}, 32'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      exp_rr = ~exp_rr;
      repeat (4) @(posedge clk);
    end
    #1 check("sat_cnt", {24'd0, conflict_cnt}, 32'd255);
    $display("txn 300 conflicts cnt=%0d", conflict_cnt);

    // Back-to-back loads accepted in RESP: one response every 3 cycles.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 16'h0005;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check("b2b_rv", {31'd0, resp_valid[0]}, (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) check("b2b_data", {16'd0, resp_data[0]}, 32'h5A5A);
    end
    req_valid[0] = 1'b0;
    $display("txn back-to-back loads port=0");
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter Ncores, default 2, number of core ports; only 2 is supported.
REQ-002 SHALL have parameter Lmem, default 8, DataMEM address width (256 words).
REQ-003 SHALL have parameter TAM, default 16, data/address word width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have ports reqValid0/1  input  1  core n request valid.
REQ-007 SHALL have ports reqWrite0/1  input  1  core n request type; 1=store, 0=load.
REQ-008 SHALL have ports reqAddr0/1  input  TAM  core n word address.
REQ-009 SHALL have ports reqData0/1  input  TAM  core n store data.
REQ-010 SHALL have ports reqReady0/1  output  1  core n request accepted when high with reqValid.
REQ-011 SHALL have ports respValid0/1  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports respData0/1  output  TAM  load data; 0 for stores.
REQ-013 SHALL have ports respErr0/1  output  1  out-of-range flag, valid with respValid.
REQ-014 SHALL have ports dataIN0/1, dataADDR0/1  output  TAM  to DataMEM.
REQ-015 SHALL have ports dataWrite, dataLoad  output  Ncores  DataMEM strobes, bit n = port n.
REQ-016 SHALL have ports dataOUT0/1  input  TAM  DataMEM read data, valid one cycle after dataLoad[n] is sampled.
REQ-017 SHALL have port conflictCnt  output  8  count of arbitration conflicts.

Function
REQ-018 SHALL run an independent per-port FSM: IDLE, ISSUE, WAIT, RESP.
REQ-019 SHALL drive reqReadyn high only in IDLE or RESP, and only when port n is not stalled by REQ-024.
REQ-020 On accept at edge e0: SHALL register address, data and type, and go to ISSUE.
REQ-021 In ISSUE: SHALL assert exactly one of dataWrite[n] or dataLoad[n] for exactly one cycle; at e1, go to WAIT.
REQ-022 In WAIT: at e2, SHALL capture dataOUTn into respDatan (loads only; stores give 0) and go to RESP.
REQ-023 In RESP: SHALL hold respValidn high for one cycle; at e3, go to ISSUE on a new accept, else IDLE. Latency is 3 edges; peak throughput is one request per 3 cycles.
REQ-024 A conflict exists when both ports would be accepted in the same cycle, reqAddr0[Lmem-1:0]==reqAddr1[Lmem-1:0], and at least one request is a store. On conflict: the port selected by rrPtr SHALL be accepted, the other SHALL see reqReady=0, and rrPtr SHALL then point to the loser.
REQ-025 Two loads to the same address SHALL both be accepted with no conflict.
REQ-026 If reqAddr[TAM-1:Lmem]!=0, the request SHALL be accepted with no strobe in ISSUE, then respErr=1 and respData=0 in RESP.
REQ-027 conflictCnt SHALL increment by 1 per conflict and saturate at 255.
REQ-028 dataINn/dataADDRn SHALL hold their last registered values outside ISSUE.

Reset
REQ-029 While rst=0, the following SHALL apply immediately, independent of clk: all FSMs in IDLE; dataWrite, dataLoad, respValid, respErr = 0; respData, dataIN, dataADDR = 0; rrPtr=0; conflictCnt=0.
REQ-030 A reset during ISSUE SHALL drop the strobe in the same cycle; no response is ever produced for the aborted request.
REQ-031 The first accept SHALL occur on the first rising edge after rst deasserts, if reqValid is high.

Structure
REQ-032 Shared package lsu_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, RESP) and the default Lmem/TAM constants.
REQ-033 The per-port FSM and its registers SHALL be sub-module lsu_port_fsm, instantiated Ncores times; arbitration, rrPtr and conflictCnt SHALL live at top level.

Verification
REQ-034 Store from port 0 to addr 0x0012 with data 0x1234, then a load from 0x0012: dataWrite[0] pulses 1 cycle; the load returns respData0=0x1234 with respValid0 three edges after accept.
REQ-035 Both ports store to 0x0040 in the same cycle with rrPtr=0: port 0 is accepted and port 1 is stalled 1 cycle; conflictCnt=1 and rrPtr=1; a readback gives port 1's data.
REQ-036 Both ports load 0x0005 in the same cycle: both are accepted, conflictCnt is unchanged, and both respData equal the memory content.
REQ-037 Load from 0x0100: no dataLoad pulse; respErr0=1 and respData0=0.
REQ-038 rst driven low during port 1 ISSUE: dataWrite[1] falls without a clock edge and no respValid1 appears; after release, a store/load pair works.
REQ-039 300 forced conflicts: conflictCnt saturates at 255; back-to-back loads accepted in RESP yield one response per 3 cycles.
